// File: rtl/snake_ctrl.sv
// Snake game controller: segment list, frame-paced moves, key steering,
// collision detection and the per-pixel body flag for the VGA colour stage.
module snake_ctrl #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned STEP_FRAMES = 8,
  parameter int unsigned CELL        = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  input  logic [11:0] apple_x,
  input  logic [11:0] apple_y,
  output logic        snake,
  output logic        apple_eaten,
  output logic        game_over,
  output logic [7:0]  score,
  output logic [5:0]  head_cx,
  output logic [5:0]  head_cy
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned FC_W  = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int unsigned CW    = 6;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DEAD} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  state_t              state_q, state_d;
  dir_t                dir, pend_dir, key_dir;
  logic                key_any;
  logic [CW-1:0]       seg_x [MAX_LEN];
  logic [CW-1:0]       seg_y [MAX_LEN];
  logic [LEN_W-1:0]    len;
  logic [FC_W-1:0]     frame_cnt;
  logic signed [7:0]   nh_x, nh_y;
  logic [11:0]         apple_cx, apple_cy;
  logic                wall_hit, self_hit, eat, pix_hit;
  logic                load_body, run_en, move_fire, do_move;

  function automatic dir_t rev_dir(input dir_t d);
    case (d)
      D_UP:    rev_dir = D_DOWN;
      D_DOWN:  rev_dir = D_UP;
      D_LEFT:  rev_dir = D_RIGHT;
      default: rev_dir = D_LEFT;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  state_d = S_RUN;
      S_RUN:   if (move_fire && (wall_hit || self_hit)) state_d = S_DEAD;
      S_DEAD:  if (start) state_d = S_INIT;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    load_body = 1'b0;
    run_en    = 1'b0;
    case (state_q)
      S_INIT:  load_body = 1'b1;
      S_RUN:   run_en    = 1'b1;
      default: ;
    endcase
    move_fire = run_en && frame_tick && (frame_cnt == FC_W'(STEP_FRAMES - 1));
    do_move   = move_fire && !wall_hit && !self_hit;
  end

  // Highest-priority key this cycle
  always_comb begin
    key_any = 1'b1;
    key_dir = D_UP;
    if (key_up)         key_dir = D_UP;
    else if (key_down)  key_dir = D_DOWN;
    else if (key_left)  key_dir = D_LEFT;
    else if (key_right) key_dir = D_RIGHT;
    else                key_any = 1'b0;
  end

  // Next head in signed cells so a step off the grid cannot wrap back in
  always_comb begin
    nh_x = $signed({2'b00, seg_x[0]});
    nh_y = $signed({2'b00, seg_y[0]});
    case (pend_dir)
      D_UP:    nh_y = nh_y - 8'sd1;
      D_DOWN:  nh_y = nh_y + 8'sd1;
      D_LEFT:  nh_x = nh_x - 8'sd1;
      default: nh_x = nh_x + 8'sd1;
    endcase
    wall_hit = (nh_x < 8'sd2) || (nh_x > 8'sd61) || (nh_y < 8'sd2) || (nh_y > 8'sd33);
    apple_cx = 12'(apple_x / 12'(CELL));
    apple_cy = 12'(apple_y / 12'(CELL));
    eat      = ({4'b0000, nh_x} == apple_cx) && ({4'b0000, nh_y} == apple_cy);
  end

  // Tail cell is free unless the snake grows this move
  always_comb begin
    self_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (((LEN_W'(i) < (len - LEN_W'(1))) || (eat && (LEN_W'(i) < len))) &&
          (seg_x[i] == nh_x[CW-1:0]) && (seg_y[i] == nh_y[CW-1:0]))
        self_hit = 1'b1;
    end
  end

  // Pixel inside any active segment
  always_comb begin
    logic [11:0] x0, y0;
    x0      = '0;
    y0      = '0;
    pix_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      x0 = 12'(seg_x[i]) * 12'(CELL);
      y0 = 12'(seg_y[i]) * 12'(CELL);
      if ((LEN_W'(i) < len) &&
          (x_pos >= x0) && (x_pos < x0 + 12'(CELL)) &&
          (y_pos >= y0) && (y_pos < y0 + 12'(CELL)))
        pix_hit = 1'b1;
    end
    if ((x_pos > 12'd1279) || (y_pos > 12'd719)) pix_hit = 1'b0;
  end

  // Body, direction, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= '0;
        seg_y[i] <= '0;
      end
      seg_x[0]    <= CW'(32);
      seg_y[0]    <= CW'(18);
      seg_x[1]    <= CW'(31);
      seg_y[1]    <= CW'(18);
      seg_x[2]    <= CW'(30);
      seg_y[2]    <= CW'(18);
      len         <= LEN_W'(3);
      dir         <= D_RIGHT;
      pend_dir    <= D_RIGHT;
      frame_cnt   <= '0;
      score       <= '0;
      snake       <= 1'b0;
      apple_eaten <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      apple_eaten <= 1'b0;
      game_over   <= (state_d == S_DEAD);
      snake       <= pix_hit;
      if (key_any && (key_dir != rev_dir(dir))) pend_dir <= key_dir;
      if (load_body) begin
        seg_x[0]  <= CW'(32);
        seg_y[0]  <= CW'(18);
        seg_x[1]  <= CW'(31);
        seg_y[1]  <= CW'(18);
        seg_x[2]  <= CW'(30);
        seg_y[2]  <= CW'(18);
        len       <= LEN_W'(3);
        dir       <= D_RIGHT;
        pend_dir  <= D_RIGHT;
        frame_cnt <= '0;
        score     <= '0;
      end else if (run_en && frame_tick) begin
        frame_cnt <= move_fire ? '0 : frame_cnt + FC_W'(1);
        if (do_move) begin
          for (int unsigned i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nh_x[CW-1:0];
          seg_y[0] <= nh_y[CW-1:0];
          dir      <= pend_dir;
          if (eat) begin
            apple_eaten <= 1'b1;
            if (len < LEN_W'(MAX_LEN)) len   <= len + LEN_W'(1);
            if (score != 8'hFF)        score <= score + 8'd1;
          end
        end
      end
    end
  end

  assign head_cx = seg_x[0];
  assign head_cy = seg_y[0];

endmodule
